// File: rtl/cpu_clk_sequencer.sv
// Clock-enable sequencer for a multi-cycle CPU: single step, fixed-length burst, prescaled free run.
// Latency: a button edge or run request seen in IDLE changes state on the next clock edge; cpu_en is decoded from that registered state.
// Backpressure: none. Button edges that arrive outside IDLE are dropped, and halt forces IDLE on the next cycle.
module cpu_clk_sequencer #(
  parameter int DIV_RUN = 50000000,
  parameter int BURST_N = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             burst_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int PW = $clog2(DIV_RUN);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_RUN - 1);
  localparam logic [7:0]    BURST_LEN  = 8'(BURST_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_BURST = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [7:0]       remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             burst_q, burst_d;
  logic             step_edge, burst_edge;
  logic             pulse;

  // Button edges, always measured against last cycle's level.
  always_comb begin
    step_d     = step_btn;
    burst_d    = burst_btn;
    step_edge  = step_btn & ~step_q;
    burst_edge = burst_btn & ~burst_q;
  end

  // cpu_en is decoded purely from registered state, so no input can reach it combinationally.
  always_comb begin
    pulse = 1'b0;
    case (state_q)
      S_STEP:  pulse = 1'b1;
      S_BURST: pulse = 1'b1;
      S_RUN:   pulse = (presc_q == PRESC_LAST);
      default: pulse = 1'b0;
    endcase
  end

  // Next-state logic: halt wins everywhere, and a burst always runs to completion.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    if (halt) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      remain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          if (run_mode) begin
            state_d = S_RUN;
          end else if (burst_edge) begin
            state_d  = S_BURST;
            remain_d = BURST_LEN;
          end else if (step_edge) begin
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          state_d = S_IDLE;
        end
        S_BURST: begin
          remain_d = remain_q - 8'd1;
          if (remain_q <= 8'd1) begin
            state_d  = S_IDLE;
            remain_d = '0;
          end
        end
        S_RUN: begin
          if (!run_mode) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Pulse counter for the display; wraps naturally at 2^CNT_W and is not touched by halt.
  always_comb begin
    cnt_d = cnt_q;
    if (pulse) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; the button copies keep tracking during reset so a held button gives no edge.
  always_ff @(posedge clk) begin
    step_q  <= step_d;
    burst_q <= burst_d;
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    cpu_en    = pulse;
    busy      = (state_q != S_IDLE);
    state     = state_q;
    cycle_cnt = cnt_q;
  end

endmodule
